// File: rtl/conv_window_gen.sv
// Streaming KxK sliding-window generator: buffers K-1 lines of a raster pixel stream
// and emits every fully-populated KxK window with valid/busy handshaking.
module conv_window_gen #(
  parameter int DATA_W = 24,
  parameter int IMG_W  = 480,
  parameter int IMG_H  = 272,
  parameter int K      = 3
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic [DATA_W-1:0]       iData,
  input  logic                    iValid,
  output logic                    oReady,
  input  logic                    iBusy,
  output logic [K*K*DATA_W-1:0]   oWin,
  output logic                    oValid,
  output logic                    oLast,
  output logic                    oFrameDone
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  generate
    if (K < 2 || K > IMG_H || K > IMG_W) begin : g_bad_k
      $fatal(1, "conv_window_gen: K must satisfy 2 <= K <= IMG_H and K <= IMG_W");
    end
  endgenerate

  logic [CW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic [K*K*DATA_W-1:0]  win_q, win_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic                   done_q, done_d;
  logic                   accept_s;
  logic [DATA_W-1:0]      lb_q [K-1][IMG_W];
  logic [DATA_W-1:0]      new_col_s [K];

  assign oReady   = !(valid_q && iBusy);
  assign accept_s = iValid && oReady;

  assign oWin       = win_q;
  assign oValid     = valid_q;
  assign oLast      = last_q;
  assign oFrameDone = done_q;

  // Row i of the incoming column is the pixel K-1-i lines above the current one.
  always_comb begin
    for (int i = 0; i < K - 1; i++) begin
      new_col_s[i] = lb_q[K-2-i][col_q];
    end
    new_col_s[K-1] = iData;
  end

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = valid_q && last_q && !iBusy;
    if (accept_s) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) begin
          win_d[(i*K+j)*DATA_W +: DATA_W] = win_q[(i*K+j+1)*DATA_W +: DATA_W];
        end
        win_d[(i*K+K-1)*DATA_W +: DATA_W] = new_col_s[i];
      end
      // Suppressing c<K-1 keeps columns of the previous line out of emitted windows.
      valid_d = (row_q >= RW'(K-1)) && (col_q >= CW'(K-1));
      last_d  = (row_q == RW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));
      if (col_q == CW'(IMG_W-1)) begin
        col_d = '0;
        if (row_q == RW'(IMG_H-1)) begin
          row_d = '0;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end else if (!iBusy) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      valid_d = valid_q;
      last_d  = last_q;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // Line buffers are plain RAM: contents survive reset and are overwritten before reuse.
  always_ff @(posedge iClk) begin
    if (accept_s) begin
      lb_q[0][col_q] <= iData;
      for (int m = 1; m < K - 1; m++) begin
        lb_q[m][col_q] <= lb_q[m-1][col_q];
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: K=3 and K=5 instances on an 8x6 image, pixel = r*8+c.
module tb_conv_window_gen;
  localparam int DW = 24;
  localparam int W  = 8;
  localparam int H  = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [DW-1:0]     d3, d5;
  logic              v3, v5, b3, b5;
  logic              rdy3, rdy5;
  logic [9*DW-1:0]   win3;
  logic [25*DW-1:0]  win5;
  logic              ov3, ol3, fd3, ov5, ol5, fd5;

  int n_checks = 0;
  int n_fail   = 0;

  conv_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .K(3)) u_k3 (
    .iClk(clk), .iRst(rst_n), .iData(d3), .iValid(v3), .oReady(rdy3), .iBusy(b3),
    .oWin(win3), .oValid(ov3), .oLast(ol3), .oFrameDone(fd3));

  conv_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .K(5)) u_k5 (
    .iClk(clk), .iRst(rst_n), .iData(d5), .iValid(v5), .oReady(rdy5), .iBusy(b5),
    .oWin(win5), .oValid(ov5), .oLast(ol5), .oFrameDone(fd5));

  function automatic logic [DW-1:0] el3(input int e);
    return win3[e*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] el5(input int e);
    return win5[e*DW +: DW];
  endfunction

  // Expected 3x3 window ending at pixel (r,c).
  function automatic logic [9*DW-1:0] exp_win3(input int r, input int c);
    logic [9*DW-1:0] v;
    v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v[(i*3+j)*DW +: DW] = DW'((r-2+i)*W + (c-2+j));
    return v;
  endfunction

  task automatic push3(input int r, input int c);
    d3 = DW'(r*W + c);
    v3 = 1'b1;
    @(posedge clk); #1;
    v3 = 1'b0;
  endtask

  task automatic idle3(input int n);
    v3 = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; d3 = '0; d5 = '0; v3 = 1'b0; v5 = 1'b0; b3 = 1'b0; b5 = 1'b0;
    #12;
    n_checks++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b exp 0", ov3); end
    n_checks++; if (ol3 !== 1'b0) begin n_fail++; $display("FAIL reset_last got %0b exp 0", ol3); end
    n_checks++; if (fd3 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b exp 0", fd3); end
    n_checks++; if (win3 !== '0) begin n_fail++; $display("FAIL reset_win got %h exp 0", win3); end
    n_checks++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b exp 1", rdy3); end
    n_checks++; if (ov5 !== 1'b0) begin n_fail++; $display("FAIL reset_valid_k5 got %0b exp 0", ov5); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_first_window;
    int r, c;
    for (int p = 0; p < W*H; p++) begin
      r = p / W; c = p % W;
      push3(r, c);
      if (r == 2 && c == 1) begin
        n_checks++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL t1_early_valid got %0b exp 0", ov3); end
      end
      if (r == 2 && c == 2) begin
        n_checks++; if (ov3 !== 1'b1) begin n_fail++; $display("FAIL t1_valid got %0b exp 1", ov3); end
        n_checks++; if (el3(0) !== DW'(0)) begin n_fail++; $display("FAIL t1_elem0 got %0d exp 0", el3(0)); end
        n_checks++; if (el3(4) !== DW'(9)) begin n_fail++; $display("FAIL t1_elem4 got %0d exp 9", el3(4)); end
        n_checks++; if (el3(8) !== DW'(18)) begin n_fail++; $display("FAIL t1_elem8 got %0d exp 18", el3(8)); end
        n_checks++; if (ol3 !== 1'b0) begin n_fail++; $display("FAIL t1_last got %0b exp 0", ol3); end
      end
    end
    idle3(3);
  endtask

  task automatic test_full_frame;
    int r, c, wins, dones;
    wins = 0; dones = 0;
    for (int p = 0; p < W*H; p++) begin
      r = p / W; c = p % W;
      push3(r, c);
      if (fd3) dones++;
      n_checks++;
      if (ov3 !== (r >= 2 && c >= 2)) begin
        n_fail++; $display("FAIL t2_valid_at_%0d_%0d got %0b exp %0b", r, c, ov3, (r >= 2 && c >= 2));
      end
      if (ov3) begin
        wins++;
        n_checks++;
        if (win3 !== exp_win3(r, c) || ol3 !== (r == H-1 && c == W-1)) begin
          n_fail++; $display("FAIL t2_window_%0d_%0d got %h/%0b exp %h", r, c, win3, ol3, exp_win3(r, c));
        end
      end
    end
    n_checks++; if (el3(0) !== DW'(29)) begin n_fail++; $display("FAIL t2_last_elem0 got %0d exp 29", el3(0)); end
    n_checks++; if (el3(8) !== DW'(47)) begin n_fail++; $display("FAIL t2_last_elem8 got %0d exp 47", el3(8)); end
    n_checks++; if (ol3 !== 1'b1) begin n_fail++; $display("FAIL t2_last_flag got %0b exp 1", ol3); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (fd3) dones++;
    end
    n_checks++; if (wins != 24) begin n_fail++; $display("FAIL t2_window_count got %0d exp 24", wins); end
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL t2_frame_done got %0d exp 1", dones); end
  endtask

  task automatic test_backpressure;
    int r, c, wins;
    wins = 0;
    for (int p = 0; p < W*H; p++) begin
      r = p / W; c = p % W;
      if (r == 3 && c == 5) begin
        b3 = 1'b1; v3 = 1'b1; d3 = DW'(29);
        repeat (5) begin
          @(posedge clk); #1;
          n_checks++;
          if (ov3 !== 1'b1 || el3(8) !== DW'(28) || rdy3 !== 1'b0 || win3 !== exp_win3(3, 4)) begin
            n_fail++; $display("FAIL t3_hold got valid=%0b elem8=%0d ready=%0b exp 1/28/0", ov3, el3(8), rdy3);
          end
        end
        b3 = 1'b0;
      end
      push3(r, c);
      n_checks++;
      if (ov3 !== (r >= 2 && c >= 2)) begin
        n_fail++; $display("FAIL t3_valid_at_%0d_%0d got %0b", r, c, ov3);
      end
      if (ov3) begin
        wins++;
        n_checks++;
        if (win3 !== exp_win3(r, c)) begin
          n_fail++; $display("FAIL t3_window_%0d_%0d got %h exp %h", r, c, win3, exp_win3(r, c));
        end
      end
    end
    n_checks++; if (wins != 24) begin n_fail++; $display("FAIL t3_window_count got %0d exp 24", wins); end
    idle3(3);
  endtask

  task automatic test_gaps;
    int idx, got, cyc;
    logic acc, cons;
    idx = 0; got = 0; cyc = 0;
    while (got < 24 && cyc < 2000) begin
      cyc++;
      v3 = (idx < W*H) ? 1'($urandom_range(0, 1)) : 1'b0;
      b3 = ($urandom_range(0, 2) == 0);
      d3 = DW'(idx);
      #1;
      acc  = v3 && rdy3;
      cons = ov3 && !b3;
      if (cons) begin
        n_checks++;
        if (win3 !== exp_win3(2 + got/6, 2 + got%6) || ol3 !== (got == 23)) begin
          n_fail++; $display("FAIL t4_window_%0d got %h/%0b exp %h", got, win3, ol3, exp_win3(2 + got/6, 2 + got%6));
        end
        got++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
    end
    v3 = 1'b0; b3 = 1'b0;
    n_checks++; if (got != 24) begin n_fail++; $display("FAIL t4_window_count got %0d exp 24", got); end
    n_checks++; if (idx != W*H) begin n_fail++; $display("FAIL t4_pixels_accepted got %0d exp %0d", idx, W*H); end
    idle3(3);
  endtask

  task automatic test_k5;
    int r, c, wins;
    wins = 0;
    for (int p = 0; p < W*H; p++) begin
      r = p / W; c = p % W;
      d5 = DW'(p); v5 = 1'b1;
      @(posedge clk); #1;
      v5 = 1'b0;
      if (ov5) wins++;
      if (r == 4 && c == 3) begin
        n_checks++; if (ov5 !== 1'b0) begin n_fail++; $display("FAIL t5_early_valid got %0b exp 0", ov5); end
      end
      if (r == 4 && c == 4) begin
        n_checks++;
        if (ov5 !== 1'b1 || el5(0) !== DW'(0) || el5(12) !== DW'(18) || el5(24) !== DW'(36)) begin
          n_fail++; $display("FAIL t5_first got v=%0b e0=%0d e12=%0d e24=%0d exp 1/0/18/36", ov5, el5(0), el5(12), el5(24));
        end
      end
    end
    n_checks++; if (ol5 !== 1'b1 || el5(24) !== DW'(47)) begin n_fail++; $display("FAIL t5_last got %0b/%0d exp 1/47", ol5, el5(24)); end
    n_checks++; if (wins != 8) begin n_fail++; $display("FAIL t5_window_count got %0d exp 8", wins); end
  endtask

  task automatic test_reset_midframe;
    int r, c, wins, lasts, dones;
    for (int p = 0; p <= 3*W + 5; p++) push3(p / W, p % W);
    n_checks++; if (ov3 !== 1'b1) begin n_fail++; $display("FAIL t6_pre_valid got %0b exp 1", ov3); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (ov3 !== 1'b0 || win3 !== '0) begin n_fail++; $display("FAIL t6_in_reset got valid=%0b win=%h exp 0", ov3, win3); end
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (rdy3 !== 1'b1 || ov3 !== 1'b0) begin n_fail++; $display("FAIL t6_after_reset got ready=%0b valid=%0b exp 1/0", rdy3, ov3); end
    wins = 0; lasts = 0; dones = 0;
    for (int p = 0; p < 2*W*H; p++) begin
      r = (p / W) % H; c = p % W;
      push3(r, c);
      if (fd3) dones++;
      if (ov3) begin
        wins++;
        if (ol3) lasts++;
        n_checks++;
        if (win3 !== exp_win3(r, c)) begin
          n_fail++; $display("FAIL t6_window_%0d_%0d got %h exp %h", r, c, win3, exp_win3(r, c));
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (fd3) dones++;
    end
    n_checks++; if (wins != 48) begin n_fail++; $display("FAIL t6_window_count got %0d exp 48", wins); end
    n_checks++; if (lasts != 2) begin n_fail++; $display("FAIL t6_last_count got %0d exp 2", lasts); end
    n_checks++; if (dones != 2) begin n_fail++; $display("FAIL t6_frame_done got %0d exp 2", dones); end
  endtask

  initial begin
    test_reset;
    test_first_window;
    test_full_frame;
    test_backpressure;
    test_gaps;
    test_k5;
    test_reset_midframe;
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
